// File: rtl/ni_output_arbiter.sv
// ============================================================================
// Module  : ni_output_arbiter
// Brief   : Round-robin, credit-gated scheduler for the NI router injection port
// Revision: 1.0
// ============================================================================
`default_nettype none

module ni_output_arbiter #(
  parameter int ROUTER_WIDTH = 36,
  parameter int CREDIT_NUM   = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    router_rdy_i,
  input  logic                    hold_req_i,
  input  logic                    rd_valid_i,
  input  logic [ROUTER_WIDTH-1:0] rd_data_i,
  output logic                    rd_grant_o,
  input  logic                    res_valid_i,
  input  logic [ROUTER_WIDTH-1:0] res_data_i,
  output logic                    res_grant_o,
  input  logic                    ctl_valid_i,
  input  logic [ROUTER_WIDTH-1:0] ctl_data_i,
  output logic                    ctl_grant_o,
  input  logic                    downstream_credit_i,
  output logic                    out_data_valid_o,
  output logic [ROUTER_WIDTH-1:0] out_data_o,
  output logic [CREDIT_WIDTH-1:0] credit_cnt_o,
  output logic                    holding_o,
  output logic                    credit_err_o
);

  localparam logic [CREDIT_WIDTH-1:0] c_credit_max = CREDIT_WIDTH'(CREDIT_NUM);
  localparam logic [1:0]              c_last_req   = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    credit_err_q, credit_err_d;
  logic                    out_valid_q, out_valid_d;
  logic [ROUTER_WIDTH-1:0] out_data_q, out_data_d;

  logic [2:0]              w_req;
  logic [2:0]              w_gnt;
  logic                    w_any;
  logic [1:0]              w_win;
  logic                    w_grant_en;
  logic [2:0]              w_idx;
  logic [ROUTER_WIDTH-1:0] w_win_data;

  assign w_req      = {ctl_valid_i, res_valid_i, rd_valid_i};
  // A credit returned this cycle is deliberately not counted here (no bypass).
  assign w_grant_en = (state_q == ST_RUN) && router_rdy_i && (credit_q != '0);

  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    w_win = rr_ptr_q;
    w_idx = '0;
    if (w_grant_en) begin
      for (int k = 0; k < 3; k++) begin
        w_idx = {1'b0, rr_ptr_q} + 3'(k);
        if (w_idx >= 3'd3) begin
          w_idx = w_idx - 3'd3;
        end
        if (!w_any && w_req[w_idx[1:0]]) begin
          w_any             = 1'b1;
          w_win             = w_idx[1:0];
          w_gnt[w_idx[1:0]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (w_win)
      2'd0:    w_win_data = rd_data_i;
      2'd1:    w_win_data = res_data_i;
      default: w_win_data = ctl_data_i;
    endcase
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    out_valid_d  = w_any;
    out_data_d   = w_any ? w_win_data : '0;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;

    if (w_any) begin
      rr_ptr_d = (w_win == c_last_req) ? 2'd0 : w_win + 2'd1;
    end

    case ({w_any, downstream_credit_i})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        // Over-return saturates and is latched as an error until reset.
        if (credit_q == c_credit_max) begin
          credit_err_d = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (hold_req_i)  state_d = ST_HOLD;
      ST_HOLD: if (!hold_req_i) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      rr_ptr_q     <= 2'd0;
      credit_q     <= c_credit_max;
      credit_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign rd_grant_o       = w_gnt[0];
  assign res_grant_o      = w_gnt[1];
  assign ctl_grant_o      = w_gnt[2];
  assign out_data_valid_o = out_valid_q;
  assign out_data_o       = out_data_q;
  assign credit_cnt_o     = credit_q;
  assign holding_o        = (state_q == ST_HOLD);
  assign credit_err_o     = credit_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ni_output_arbiter.sv
// ============================================================================
// Module  : tb_ni_output_arbiter
// Brief   : Directed self-checking bench for ni_output_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ni_output_arbiter;

  localparam int RW = 36;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          router_rdy_i, hold_req_i;
  logic          rd_valid_i, res_valid_i, ctl_valid_i;
  logic [RW-1:0] rd_data_i, res_data_i, ctl_data_i;
  logic          rd_grant_o, res_grant_o, ctl_grant_o;
  logic          downstream_credit_i;
  logic          out_data_valid_o;
  logic [RW-1:0] out_data_o;
  logic [2:0]    credit_cnt_o;
  logic          holding_o, credit_err_o;
  logic [2:0]    w_gnt;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [RW-1:0] D0 = 36'h1_0001_AAAA;
  localparam logic [RW-1:0] D1 = 36'h2_0002_BBBB;
  localparam logic [RW-1:0] D2 = 36'h3_0003_CCCC;

  assign w_gnt = {ctl_grant_o, res_grant_o, rd_grant_o};

  always #5 clk = ~clk;

  ni_output_arbiter #(
    .ROUTER_WIDTH(RW), .CREDIT_NUM(4), .CREDIT_WIDTH(3)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .router_rdy_i       (router_rdy_i),
    .hold_req_i         (hold_req_i),
    .rd_valid_i         (rd_valid_i),
    .rd_data_i          (rd_data_i),
    .rd_grant_o         (rd_grant_o),
    .res_valid_i        (res_valid_i),
    .res_data_i         (res_data_i),
    .res_grant_o        (res_grant_o),
    .ctl_valid_i        (ctl_valid_i),
    .ctl_data_i         (ctl_data_i),
    .ctl_grant_o        (ctl_grant_o),
    .downstream_credit_i(downstream_credit_i),
    .out_data_valid_o   (out_data_valid_o),
    .out_data_o         (out_data_o),
    .credit_cnt_o       (credit_cnt_o),
    .holding_o          (holding_o),
    .credit_err_o       (credit_err_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    router_rdy_i = 1'b1;
    hold_req_i = 1'b0;
    rd_valid_i = 1'b0; res_valid_i = 1'b0; ctl_valid_i = 1'b0;
    rd_data_i = D0; res_data_i = D1; ctl_data_i = D2;
    downstream_credit_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check_val("rst_valid", 64'(out_data_valid_o), 64'd0);
    check_val("rst_data", 64'(out_data_o), 64'd0);
    check_val("rst_credit", 64'(credit_cnt_o), 64'd4);
    check_val("rst_hold", 64'(holding_o), 64'd0);
    check_val("rst_err", 64'(credit_err_o), 64'd0);
    next_cyc();

    // 1: all valid with constant credit return -> rd,res,ctl,rd
    rd_valid_i = 1'b1; res_valid_i = 1'b1; ctl_valid_i = 1'b1;
    downstream_credit_i = 1'b1;
    @(negedge clk);
    check_val("t1_g0", 64'(w_gnt), 64'b001);
    check_val("t1_v0", 64'(out_data_valid_o), 64'd0);
    next_cyc();
    @(negedge clk);
    check_val("t1_g1", 64'(w_gnt), 64'b010);
    check_val("t1_v1", 64'(out_data_valid_o), 64'd1);
    check_val("t1_d1", 64'(out_data_o), 64'(D0));
    check_val("t1_c1", 64'(credit_cnt_o), 64'd4);
    next_cyc();
    @(negedge clk);
    check_val("t1_g2", 64'(w_gnt), 64'b100);
    check_val("t1_d2", 64'(out_data_o), 64'(D1));
    next_cyc();
    @(negedge clk);
    check_val("t1_g3", 64'(w_gnt), 64'b001);
    check_val("t1_d3", 64'(out_data_o), 64'(D2));
    next_cyc();
    rd_valid_i = 1'b0; res_valid_i = 1'b0; ctl_valid_i = 1'b0;
    downstream_credit_i = 1'b0;
    @(negedge clk);
    check_val("t1_g4", 64'(w_gnt), 64'b000);
    check_val("t1_d4", 64'(out_data_o), 64'(D0));
    check_val("t1_c4", 64'(credit_cnt_o), 64'd4);
    next_cyc();
    @(negedge clk);
    check_val("t1_v5", 64'(out_data_valid_o), 64'd0);
    check_val("t1_d5", 64'(out_data_o), 64'd0);

    // 2: res only, no credit return -> exactly 4 grants
    do_reset();
    res_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t2_gnt", 64'(res_grant_o), 64'd1);
      check_val("t2_cred", 64'(credit_cnt_o), 64'(4 - i));
      if (i > 0) check_val("t2_data", 64'(out_data_o), 64'(D1));
      next_cyc();
    end
    @(negedge clk);
    check_val("t2_starve_g", 64'(res_grant_o), 64'd0);
    check_val("t2_starve_c", 64'(credit_cnt_o), 64'd0);
    check_val("t2_last_v", 64'(out_data_valid_o), 64'd1);
    next_cyc();
    @(negedge clk);
    check_val("t2_idle_v", 64'(out_data_valid_o), 64'd0);
    next_cyc();
    downstream_credit_i = 1'b1;
    @(negedge clk);
    check_val("t2_ret_g", 64'(res_grant_o), 64'd0);
    next_cyc();
    downstream_credit_i = 1'b0;
    @(negedge clk);
    check_val("t2_after_g", 64'(res_grant_o), 64'd1);
    check_val("t2_after_c", 64'(credit_cnt_o), 64'd1);
    next_cyc();

    // 3: credit returned at zero is not bypassed
    res_valid_i = 1'b0;
    rd_valid_i = 1'b1;
    downstream_credit_i = 1'b1;
    @(negedge clk);
    check_val("t3_zero_c", 64'(credit_cnt_o), 64'd0);
    check_val("t3_nobyp", 64'(rd_grant_o), 64'd0);
    next_cyc();
    downstream_credit_i = 1'b0;
    @(negedge clk);
    check_val("t3_gnt", 64'(rd_grant_o), 64'd1);
    check_val("t3_c1", 64'(credit_cnt_o), 64'd1);
    next_cyc();
    rd_valid_i = 1'b0;
    @(negedge clk);
    check_val("t3_c0", 64'(credit_cnt_o), 64'd0);
    check_val("t3_data", 64'(out_data_o), 64'(D0));

    // 4: simultaneous grant+return, then over-return
    do_reset();
    res_valid_i = 1'b1;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    next_cyc();
    downstream_credit_i = 1'b1;
    @(negedge clk);
    check_val("t4_c2", 64'(credit_cnt_o), 64'd2);
    check_val("t4_g", 64'(res_grant_o), 64'd1);
    next_cyc();
    res_valid_i = 1'b0;
    @(negedge clk);
    check_val("t4_same", 64'(credit_cnt_o), 64'd2);
    next_cyc();
    @(negedge clk);
    check_val("t4_c3", 64'(credit_cnt_o), 64'd3);
    next_cyc();
    @(negedge clk);
    check_val("t4_c4", 64'(credit_cnt_o), 64'd4);
    check_val("t4_noerr", 64'(credit_err_o), 64'd0);
    next_cyc();
    downstream_credit_i = 1'b0;
    @(negedge clk);
    check_val("t4_sat", 64'(credit_cnt_o), 64'd4);
    check_val("t4_err", 64'(credit_err_o), 64'd1);
    next_cyc();
    @(negedge clk);
    check_val("t4_sticky", 64'(credit_err_o), 64'd1);

    // 5: hold after one grant, resume round-robin where it left off
    do_reset();
    rd_valid_i = 1'b1; res_valid_i = 1'b1; ctl_valid_i = 1'b1;
    hold_req_i = 1'b1;
    @(negedge clk);
    check_val("t5_g0", 64'(w_gnt), 64'b001);
    check_val("t5_h0", 64'(holding_o), 64'd0);
    next_cyc();
    @(negedge clk);
    check_val("t5_g1", 64'(w_gnt), 64'b000);
    check_val("t5_h1", 64'(holding_o), 64'd1);
    check_val("t5_c1", 64'(credit_cnt_o), 64'd3);
    next_cyc();
    downstream_credit_i = 1'b1;
    @(negedge clk);
    check_val("t5_g2", 64'(w_gnt), 64'b000);
    next_cyc();
    downstream_credit_i = 1'b0;
    hold_req_i = 1'b0;
    @(negedge clk);
    check_val("t5_g3", 64'(w_gnt), 64'b000);
    check_val("t5_h3", 64'(holding_o), 64'd1);
    check_val("t5_c3", 64'(credit_cnt_o), 64'd4);
    next_cyc();
    @(negedge clk);
    check_val("t5_h4", 64'(holding_o), 64'd0);
    check_val("t5_g4", 64'(w_gnt), 64'b010);
    next_cyc();
    @(negedge clk);
    check_val("t5_g5", 64'(w_gnt), 64'b100);

    // 6: router not ready, then async reset with a flit in flight
    do_reset();
    rd_valid_i = 1'b1; res_valid_i = 1'b1; ctl_valid_i = 1'b1;
    router_rdy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("t6_nordy_g", 64'(w_gnt), 64'b000);
      check_val("t6_nordy_c", 64'(credit_cnt_o), 64'd4);
      next_cyc();
    end
    router_rdy_i = 1'b1;
    @(negedge clk);
    check_val("t6_g", 64'(w_gnt), 64'b001);
    next_cyc();
    check_val("t6_inflight_v", 64'(out_data_valid_o), 64'd1);
    check_val("t6_inflight_c", 64'(credit_cnt_o), 64'd3);
    rst_n = 1'b0;
    #1;
    check_val("t6_arst_v", 64'(out_data_valid_o), 64'd0);
    check_val("t6_arst_d", 64'(out_data_o), 64'd0);
    check_val("t6_arst_c", 64'(credit_cnt_o), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
